// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: operand forwarding select, load-use bubble sequencing,
// data-memory freeze and a saturating stall-cycle counter.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   src_reg, src_used     per-operand source index and read enable
//   stg_dst, stg_wen      per-stage destination index and write enable
//   stg_load              per-stage load flag
//   ihit, dmem_req, dhit  fetch done, data request active, data done
//   clr_count             synchronous clear of stall_count
//   fwd_sel               per-operand select: 0 = regfile, k+1 = stage k
//   stall_if_id           hold PC and IF/ID
//   flush_id_ex           insert a bubble into ID/EX
//   freeze_all            hold all pipeline registers
//   pc_en                 PC may advance
//   stall_count           saturating count of stalled/frozen cycles
module hazard_ctrl_unit #(
    parameter int NSRC         = 2,
    parameter int NFWD         = 2,
    parameter int REGW         = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNTW         = 16,
    parameter int SELW         = $clog2(NFWD + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NSRC*REGW-1:0] src_reg,
    input  logic [NSRC-1:0]      src_used,
    input  logic [NFWD*REGW-1:0] stg_dst,
    input  logic [NFWD-1:0]      stg_wen,
    input  logic [NFWD-1:0]      stg_load,
    input  logic                 ihit,
    input  logic                 dmem_req,
    input  logic                 dhit,
    input  logic                 clr_count,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall_if_id,
    output logic                 flush_id_ex,
    output logic                 freeze_all,
    output logic                 pc_en,
    output logic [CNTW-1:0]      stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [1:0] bcnt, bcnt_nxt;
    logic ret_lu, ret_lu_nxt;

    logic [NSRC*SELW-1:0] sel_raw;
    logic [1:0] lu_cnt;
    logic lu_hit;
    logic mem_miss;
    logic stall_raw, flush_raw, freeze_raw;

    // Per operand: scan farthest to nearest so the nearest match wins.
    // A winning load still in a stage below LOAD_BUBBLES needs
    // LOAD_BUBBLES-k bubbles; the largest need across operands is kept.
    always_comb begin
        logic found;
        logic ld_hit;
        logic [1:0] need;
        logic [SELW-1:0] sel;
        sel_raw = '0;
        lu_cnt  = 2'd0;
        found   = 1'b0;
        ld_hit  = 1'b0;
        need    = 2'd0;
        sel     = '0;
        for (int i = 0; i < NSRC; i++) begin
            found  = 1'b0;
            ld_hit = 1'b0;
            need   = 2'd0;
            sel    = '0;
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (stg_wen[k] &&
                    stg_dst[k*REGW +: REGW] == src_reg[i*REGW +: REGW] &&
                    stg_dst[k*REGW +: REGW] != '0) begin
                    found  = 1'b1;
                    sel    = SELW'(k + 1);
                    ld_hit = stg_load[k] && (k < LOAD_BUBBLES);
                    need   = 2'(LOAD_BUBBLES - k);
                end
            end
            if (src_used[i] && found) begin
                sel_raw[i*SELW +: SELW] = sel;
                if (ld_hit && need > lu_cnt) begin
                    lu_cnt = need;
                end
            end
        end
    end

    assign lu_hit   = (lu_cnt != 2'd0);
    assign mem_miss = dmem_req & ~dhit;

    always_ff @(posedge CLK) begin
        state  <= state_nxt;
        bcnt   <= bcnt_nxt;
        ret_lu <= ret_lu_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bcnt_nxt   = bcnt;
        ret_lu_nxt = ret_lu;
        unique case (state)
            RUN: begin
                if (mem_miss) begin
                    state_nxt  = MEM_WAIT;
                    ret_lu_nxt = 1'b0;
                end else if (lu_cnt > 2'd1) begin
                    bcnt_nxt  = lu_cnt - 2'd1;
                    state_nxt = LU_STALL;
                end
            end
            LU_STALL: begin
                // bcnt is held across the memory wait
                if (mem_miss) begin
                    state_nxt  = MEM_WAIT;
                    ret_lu_nxt = 1'b1;
                end else begin
                    bcnt_nxt = bcnt - 2'd1;
                    if (bcnt == 2'd1) begin
                        state_nxt = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (dhit) begin
                    state_nxt = ret_lu ? LU_STALL : RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (RST) begin
            state_nxt  = RUN;
            bcnt_nxt   = 2'd0;
            ret_lu_nxt = 1'b0;
        end
    end

    always_comb begin
        stall_raw  = 1'b0;
        flush_raw  = 1'b0;
        freeze_raw = 1'b0;
        unique case (state)
            RUN: begin
                freeze_raw = mem_miss;
                stall_raw  = ~mem_miss & lu_hit;
                flush_raw  = ~mem_miss & lu_hit;
            end
            LU_STALL: begin
                freeze_raw = mem_miss;
                stall_raw  = ~mem_miss;
                flush_raw  = ~mem_miss;
            end
            MEM_WAIT: freeze_raw = ~dhit;
            default: ;
        endcase
    end

    assign fwd_sel     = RST ? '0 : sel_raw;
    assign stall_if_id = stall_raw & ~RST;
    assign flush_id_ex = flush_raw & ~RST;
    assign freeze_all  = freeze_raw & ~RST;
    assign pc_en       = ihit & ~stall_if_id & ~freeze_all & ~RST;

    always_ff @(posedge CLK) begin
        if (RST || clr_count) begin
            stall_count <= '0;
        end else if ((stall_if_id || freeze_all) && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed vectors with a cycle-tagged scoreboard,
// driving two instances (LOAD_BUBBLES=1/CNTW=16 and LOAD_BUBBLES=3/CNTW=4).
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  src_reg;
    logic [1:0]  src_used;
    logic [9:0]  stg_dst;
    logic [1:0]  stg_wen;
    logic [1:0]  stg_load;
    logic        ihit, dmem_req, dhit, clr_count;

    logic [3:0]  fwd_a, fwd_b;
    logic        st_a, fl_a, fz_a, pc_a;
    logic        st_b, fl_b, fz_b, pc_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .NSRC(2), .NFWD(2), .REGW(5), .LOAD_BUBBLES(1), .CNTW(16)
    ) dut_a (
        .CLK(clk), .RST(rst),
        .src_reg(src_reg), .src_used(src_used),
        .stg_dst(stg_dst), .stg_wen(stg_wen), .stg_load(stg_load),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .clr_count(clr_count),
        .fwd_sel(fwd_a), .stall_if_id(st_a), .flush_id_ex(fl_a),
        .freeze_all(fz_a), .pc_en(pc_a), .stall_count(cnt_a)
    );

    hazard_ctrl_unit #(
        .NSRC(2), .NFWD(2), .REGW(5), .LOAD_BUBBLES(3), .CNTW(4)
    ) dut_b (
        .CLK(clk), .RST(rst),
        .src_reg(src_reg), .src_used(src_used),
        .stg_dst(stg_dst), .stg_wen(stg_wen), .stg_load(stg_load),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .clr_count(clr_count),
        .fwd_sel(fwd_b), .stall_if_id(st_b), .flush_id_ex(fl_b),
        .freeze_all(fz_b), .pc_en(pc_b), .stall_count(cnt_b)
    );

    typedef struct {
        int   cyc;
        int   f0;
        int   f1;
        logic st;
        logic fl;
        logic fz;
        logic pc;
        int   cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc_no = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic cmp(input string nm, input int cyc,
                       input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d",
                     nm, cyc, act, want);
        end
    endtask

    task automatic chk(input string id, input exp_t e, input logic [3:0] f,
                       input logic st, input logic fl, input logic fz,
                       input logic pc, input int cnt);
        cmp({id, ".fwd0"}, e.cyc, int'(f[1:0]), e.f0);
        cmp({id, ".fwd1"}, e.cyc, int'(f[3:2]), e.f1);
        cmp({id, ".stall"}, e.cyc, int'(st), int'(e.st));
        cmp({id, ".flush"}, e.cyc, int'(fl), int'(e.fl));
        cmp({id, ".freeze"}, e.cyc, int'(fz), int'(e.fz));
        cmp({id, ".pc_en"}, e.cyc, int'(pc), int'(e.pc));
        cmp({id, ".count"}, e.cyc, cnt, e.cnt);
    endtask

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge clk) begin
        exp_t ea_e, eb_e;
        while (qa.size() > 0 && qa[0].cyc == cyc_no) begin
            ea_e = qa.pop_front();
            chk("a", ea_e, fwd_a, st_a, fl_a, fz_a, pc_a, int'(cnt_a));
        end
        while (qb.size() > 0 && qb[0].cyc == cyc_no) begin
            eb_e = qb.pop_front();
            chk("b", eb_e, fwd_b, st_b, fl_b, fz_b, pc_b, int'(cnt_b));
        end
    end

    task automatic go(input logic r, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] u, input logic [4:0] d0,
                      input logic [4:0] d1, input logic [1:0] w,
                      input logic [1:0] ld, input logic ih, input logic dq,
                      input logic dh, input logic cl);
        @(posedge clk);
        #1;
        rst       = r;
        src_reg   = {s1, s0};
        src_used  = u;
        stg_dst   = {d1, d0};
        stg_wen   = w;
        stg_load  = ld;
        ihit      = ih;
        dmem_req  = dq;
        dhit      = dh;
        clr_count = cl;
    endtask

    task automatic idle(input logic dq, input logic dh, input logic cl);
        go(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, dq, dh, cl);
    endtask

    task automatic ea(input int f0, input int f1, input logic st,
                      input logic fl, input logic fz, input logic pc,
                      input int cnt);
        exp_t e;
        e = '{cyc_no, f0, f1, st, fl, fz, pc, cnt};
        qa.push_back(e);
    endtask

    task automatic eb(input int f0, input int f1, input logic st,
                      input logic fl, input logic fz, input logic pc,
                      input int cnt);
        exp_t e;
        e = '{cyc_no, f0, f1, st, fl, fz, pc, cnt};
        qb.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        src_reg = '0; src_used = '0; stg_dst = '0;
        stg_wen = '0; stg_load = '0;
        ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; clr_count = 1'b0;

        // reset held: outputs forced low despite hazards on the inputs
        go(1, 5, 0, 2'b01, 5, 0, 2'b01, 2'b01, 1, 1, 0, 0);
        ea(0, 0, 0, 0, 0, 0, 0); eb(0, 0, 0, 0, 0, 0, 0);

        // forwarding priority
        go(0, 5, 7, 2'b11, 5, 5, 2'b11, 2'b00, 1, 0, 0, 0);
        ea(1, 0, 0, 0, 0, 1, 0); eb(1, 0, 0, 0, 0, 1, 0);
        go(0, 5, 5, 2'b01, 5, 5, 2'b10, 2'b00, 1, 0, 0, 0);
        ea(2, 0, 0, 0, 0, 1, 0); eb(2, 0, 0, 0, 0, 1, 0);
        go(0, 0, 0, 2'b11, 0, 0, 2'b11, 2'b00, 1, 0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 0); eb(0, 0, 0, 0, 0, 1, 0);
        go(0, 5, 7, 2'b11, 5, 7, 2'b11, 2'b00, 0, 0, 0, 0);
        ea(1, 2, 0, 0, 0, 0, 0); eb(1, 2, 0, 0, 0, 0, 0);

        // load at stage0 feeding operand1: 1 bubble (a), 3 bubbles (b)
        go(0, 0, 3, 2'b10, 3, 9, 2'b11, 2'b01, 1, 0, 0, 0);
        ea(0, 1, 1, 1, 0, 0, 0); eb(0, 1, 1, 1, 0, 0, 0);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 1); eb(0, 0, 1, 1, 0, 0, 1);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 1); eb(0, 0, 1, 1, 0, 0, 2);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 1); eb(0, 0, 0, 0, 0, 1, 3);

        // load at stage1: forwardable for a, 2 bubbles for b
        go(0, 4, 0, 2'b01, 8, 4, 2'b11, 2'b10, 1, 0, 0, 0);
        ea(2, 0, 0, 0, 0, 1, 1); eb(2, 0, 1, 1, 0, 0, 3);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 1); eb(0, 0, 1, 1, 0, 0, 4);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 1); eb(0, 0, 0, 0, 0, 1, 5);

        // memory wait interrupting a 3-bubble stall
        go(0, 0, 3, 2'b10, 3, 9, 2'b11, 2'b01, 1, 0, 0, 0);
        ea(0, 1, 1, 1, 0, 0, 1); eb(0, 1, 1, 1, 0, 0, 5);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 2); eb(0, 0, 1, 1, 0, 0, 6);
        for (int j = 0; j < 4; j++) begin
            idle(1, 0, 0);
            ea(0, 0, 0, 0, 1, 0, 2 + j); eb(0, 0, 0, 0, 1, 0, 7 + j);
        end
        idle(1, 1, 0);
        ea(0, 0, 0, 0, 0, 1, 6); eb(0, 0, 0, 0, 0, 1, 11);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 6); eb(0, 0, 1, 1, 0, 0, 11);
        // request with immediate dhit: no freeze
        idle(1, 1, 0);
        ea(0, 0, 0, 0, 0, 1, 6); eb(0, 0, 0, 0, 0, 1, 12);

        // load-use together with memory miss: freeze wins, then re-check
        go(0, 0, 3, 2'b10, 3, 9, 2'b11, 2'b01, 1, 1, 0, 0);
        ea(0, 1, 0, 0, 1, 0, 6); eb(0, 1, 0, 0, 1, 0, 12);
        go(0, 0, 3, 2'b10, 3, 9, 2'b11, 2'b01, 1, 1, 1, 0);
        ea(0, 1, 0, 0, 0, 1, 7); eb(0, 1, 0, 0, 0, 1, 13);
        go(0, 0, 3, 2'b10, 3, 9, 2'b11, 2'b01, 1, 0, 0, 0);
        ea(0, 1, 1, 1, 0, 0, 7); eb(0, 1, 1, 1, 0, 0, 13);

        // enter MEM_WAIT, then reset in the middle of it
        idle(1, 0, 0);
        ea(0, 0, 0, 0, 1, 0, 8); eb(0, 0, 0, 0, 1, 0, 14);
        go(1, 5, 0, 2'b01, 5, 0, 2'b01, 2'b00, 1, 1, 0, 0);
        ea(0, 0, 0, 0, 0, 0, 9); eb(0, 0, 0, 0, 0, 0, 15);
        go(0, 5, 0, 2'b01, 5, 0, 2'b01, 2'b00, 1, 0, 0, 0);
        ea(1, 0, 0, 0, 0, 1, 0); eb(1, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 0); eb(0, 0, 0, 0, 0, 1, 0);

        // 20 frozen cycles: b saturates at 15, then clear wins over +1
        for (int j = 0; j < 20; j++) begin
            idle(1, 0, 0);
            ea(0, 0, 0, 0, 1, 0, j);
            eb(0, 0, 0, 0, 1, 0, (j > 15) ? 15 : j);
        end
        idle(1, 0, 1);
        ea(0, 0, 0, 0, 1, 0, 20); eb(0, 0, 0, 0, 1, 0, 15);
        idle(1, 1, 0);
        ea(0, 0, 0, 0, 0, 1, 0); eb(0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0);
        ea(0, 0, 0, 0, 0, 1, 0); eb(0, 0, 0, 0, 0, 1, 0);

        @(negedge clk);
        #1;
        cmp("pending_a", cyc_no, qa.size(), 0);
        cmp("pending_b", cyc_no, qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
